// File: rtl/adc_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : adc_capture                                                       |
// | Arms on a PS GPIO edge, captures a block of ADC beats after a trigger edge |
// | into a FWFT FIFO and streams it back to the PS over AXIS with tlast.       |
// | Optional feature macro: ADC_TIMESTAMP_EN (timestamp header beat).          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adc_capture #(
   parameter int DEPTH_LOG2 = 10,
   parameter int ARM_BIT    = 0,
   parameter int FLUSH_BIT  = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [15:0]  gpio_ctrl_ext,
   input  logic [15:0]  capture_len,
   input  logic [255:0] s_axis_tdata,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   input  logic         trigger_in,
   input  logic         select_in,
   output logic [255:0] m_axis_tdata,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic         m_axis_tlast,
   output logic         capture_busy,
   output logic         capture_done
);

   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef ADC_TIMESTAMP_EN
   localparam int MAX_LEN = DEPTH - 1;
`else
   localparam int MAX_LEN = DEPTH;
`endif
   localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     gpio_ctrl_q;
   logic            trig_q, trig_prev_q, arm_prev_q;
   logic            ready_q;
   logic [PW-1:0]   len_q, len_d;
   logic [PW-1:0]   cnt_q, cnt_d;
   logic            wr_en_q, wr_en_d;
   logic [256:0]    wr_data_q, wr_data_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            done_q, done_d;
   logic [256:0]    fifo_mem [DEPTH];

   logic            arm_edge, trig_edge, flush;
   logic            fifo_empty, fifo_drained, pop, take_beat, is_last, mem_we;
   logic [256:0]    rd_word;
   logic [PW-1:0]   len_clamped;

`ifdef ADC_TIMESTAMP_EN
   logic [63:0]     ts_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ts_q <= '0;
      else      ts_q <= ts_q + 64'd1;
   end
`endif

   assign arm_edge  = gpio_ctrl_q[ARM_BIT] & ~arm_prev_q;
   assign trig_edge = trig_q & ~trig_prev_q;
   assign flush     = gpio_ctrl_q[FLUSH_BIT];

   assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
   // A write still sitting in the input stage counts as FIFO content for arming
   assign fifo_drained = fifo_empty & ~wr_en_q;
   assign pop          = ~fifo_empty & m_axis_tready;
   assign mem_we       = wr_en_q & ~flush;
   assign is_last      = (cnt_q == len_q - PW'(1));
   assign len_clamped  = ({1'b0, capture_len} > MAX_LEN_W) ? MAX_LEN_W[PW-1:0]
                                                           : capture_len[PW-1:0];

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_data_d = {1'b0, s_axis_tdata};
      done_d    = 1'b0;
      take_beat = 1'b0;
      wr_ptr_d  = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, wr_en_q};
      rd_ptr_d  = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};

      if (flush) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = wr_ptr_q;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm_edge && select_in && fifo_drained && (capture_len != 16'd0)) begin
                  state_d = S_ARMED;
                  len_d   = len_clamped;
                  cnt_d   = '0;
               end
            end
            S_ARMED: begin
               if (trig_edge) begin
                  state_d = S_CAPTURE;
`ifdef ADC_TIMESTAMP_EN
                  wr_en_d   = 1'b1;
                  wr_data_d = {1'b0, 192'h0, ts_q};
`else
                  take_beat = s_axis_tvalid;
`endif
               end
            end
            S_CAPTURE: take_beat = s_axis_tvalid;
            default:   state_d = S_IDLE;
         endcase

         if (take_beat) begin
            wr_en_d   = 1'b1;
            wr_data_d = {is_last, s_axis_tdata};
            cnt_d     = cnt_q + PW'(1);
            if (is_last) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         gpio_ctrl_q <= '0;
         trig_q      <= 1'b0;
         trig_prev_q <= 1'b0;
         arm_prev_q  <= 1'b0;
         ready_q     <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gpio_ctrl_q <= gpio_ctrl_ext;
         trig_q      <= trigger_in;
         trig_prev_q <= trig_q;
         arm_prev_q  <= gpio_ctrl_q[ARM_BIT];
         ready_q     <= 1'b1;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) fifo_mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_q;
   end

   assign rd_word       = fifo_mem[rd_ptr_q[DEPTH_LOG2-1:0]];
   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tdata  = fifo_empty ? 256'h0 : rd_word[255:0];
   assign m_axis_tlast  = ~fifo_empty & rd_word[256];
   assign s_axis_tready = ready_q;
   assign capture_busy  = (state_q != S_IDLE);
   assign capture_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_adc_capture                                                    |
// | Scoreboard bench for adc_capture (default build, DEPTH_LOG2 = 10).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_adc_capture;

   localparam int DEPTH = 1024;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  gpio_ctrl_ext;
   logic [15:0]  capture_len;
   logic [255:0] s_axis_tdata;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic         trigger_in;
   logic         select_in;
   logic [255:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic         m_axis_tlast;
   logic         capture_busy;
   logic         capture_done;

   logic [256:0] sb [$];
   int           n_tests = 0;
   int           n_fail  = 0;
   int           done_cnt = 0;
   int           done_ref;
   logic         hold_pend = 1'b0;
   logic [256:0] held;

   always #5 clk = ~clk;

   adc_capture dut (
      .clk           (clk),
      .rst           (rst),
      .gpio_ctrl_ext (gpio_ctrl_ext),
      .capture_len   (capture_len),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .trigger_in    (trigger_in),
      .select_in     (select_in),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .capture_busy  (capture_busy),
      .capture_done  (capture_done)
   );

   task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard pops on handshake, stability check while stalled
   always @(negedge clk) begin
      if (rst) begin
         if (hold_pend && m_axis_tvalid)
            check("hold_stable", {m_axis_tlast, m_axis_tdata}, held);
         hold_pend = m_axis_tvalid && !m_axis_tready;
         held      = {m_axis_tlast, m_axis_tdata};
         if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) check("unexpected_beat", m_axis_tvalid, 1'b0);
            else check("beat", {m_axis_tlast, m_axis_tdata}, sb.pop_front());
         end
         if (capture_done) done_cnt++;
      end
   end

   task automatic do_arm(input int len);
      capture_len      = 16'(len);
      gpio_ctrl_ext[0] = 1'b1;
      repeat (2) tick();
      gpio_ctrl_ext[0] = 1'b0;
      repeat (2) tick();
   endtask

   // Trigger, then drive nbeats ADC cycles; valid pattern from mask (LSB first, then all valid)
   task automatic run_capture(input int len, input logic [31:0] mask, input int nbeats, input bit expect_cap);
      int leff;
      int cnt;
      logic v;
      logic [255:0] d;
      leff = (len > DEPTH) ? DEPTH : len;
      cnt  = 0;
      trigger_in    = 1'b1;
      s_axis_tvalid = 1'b0;
      tick();
      for (int i = 0; i < nbeats; i++) begin
         v = (i < 32) ? mask[i] : 1'b1;
         for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
         s_axis_tdata  = d;
         s_axis_tvalid = v;
         if (expect_cap && v && cnt < leff) begin
            sb.push_back({(cnt == leff - 1), d});
            cnt++;
         end
         tick();
      end
      s_axis_tvalid = 1'b0;
      trigger_in    = 1'b0;
      tick();
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         tick();
         n++;
      end
      check("drain_left", sb.size(), 0);
      repeat (3) tick();
      check("drain_tvalid", m_axis_tvalid, 1'b0);
   endtask

   initial begin
      rst           = 1'b0;
      gpio_ctrl_ext = '0;
      capture_len   = '0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      trigger_in    = 1'b0;
      select_in     = 1'b1;
      m_axis_tready = 1'b1;
      repeat (3) tick();
      check("rst_s_tready", s_axis_tready, 1'b0);
      check("rst_m_tvalid", m_axis_tvalid, 1'b0);
      check("rst_busy", capture_busy, 1'b0);
      check("rst_done", capture_done, 1'b0);
      check("rst_m_data", {m_axis_tlast, m_axis_tdata}, '0);
      rst = 1'b1;
      tick();
      check("s_tready_up", s_axis_tready, 1'b1);

      // 1: basic capture of 4 from 8 continuous beats
      done_ref = done_cnt;
      do_arm(4);
      check("t1_busy", capture_busy, 1'b1);
      run_capture(4, 32'hFFFF_FFFF, 8, 1'b1);
      wait_drain();
      check("t1_done_cnt", done_cnt, done_ref + 1);
      check("t1_idle", capture_busy, 1'b0);

      // 2: gapped tvalid
      done_ref = done_cnt;
      do_arm(4);
      run_capture(4, 32'b110101, 6, 1'b1);
      wait_drain();
      check("t2_done_cnt", done_cnt, done_ref + 1);

      // 3: back-pressure during capture
      m_axis_tready = 1'b0;
      do_arm(4);
      run_capture(4, 32'hFFFF_FFFF, 6, 1'b1);
      repeat (5) tick();
      check("t3_tvalid_held", m_axis_tvalid, 1'b1);
      check("t3_sb_intact", sb.size(), 4);
      m_axis_tready = 1'b1;
      wait_drain();

      // 4: len clamp to FIFO depth
      done_ref = done_cnt;
      do_arm(2000);
      run_capture(2000, 32'hFFFF_FFFF, 1100, 1'b1);
      wait_drain();
      check("t4_done_cnt", done_cnt, done_ref + 1);

      // 5a: arm with select_in low
      select_in = 1'b0;
      do_arm(4);
      check("t5_sel_busy", capture_busy, 1'b0);
      run_capture(4, 32'hFFFF_FFFF, 8, 1'b0);
      repeat (4) tick();
      check("t5_sel_tvalid", m_axis_tvalid, 1'b0);
      select_in = 1'b1;

      // 5b: arm with FIFO non-empty
      m_axis_tready = 1'b0;
      do_arm(4);
      run_capture(4, 32'hFFFF_FFFF, 6, 1'b1);
      repeat (3) tick();
      do_arm(4);
      check("t5_full_busy", capture_busy, 1'b0);
      run_capture(4, 32'hFFFF_FFFF, 6, 1'b0);
      m_axis_tready = 1'b1;
      wait_drain();

      // 6: flush after 2 of 8 beats, then fresh capture
      done_ref      = done_cnt;
      m_axis_tready = 1'b0;
      do_arm(8);
      trigger_in = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         s_axis_tdata  = {8{$urandom}};
         s_axis_tvalid = 1'b1;
         tick();
      end
      gpio_ctrl_ext[1] = 1'b1;
      s_axis_tvalid    = 1'b0;
      tick();
      tick();
      check("t6_flush_tvalid", m_axis_tvalid, 1'b0);
      check("t6_flush_busy", capture_busy, 1'b0);
      tick();
      gpio_ctrl_ext[1] = 1'b0;
      trigger_in       = 1'b0;
      tick();
      check("t6_post_tvalid", m_axis_tvalid, 1'b0);
      check("t6_no_done", done_cnt, done_ref);
      m_axis_tready = 1'b1;
      do_arm(8);
      check("t6_rearm_busy", capture_busy, 1'b1);
      run_capture(8, 32'hFFFF_FFFF, 10, 1'b1);
      wait_drain();
      check("t6_done_cnt", done_cnt, done_ref + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
      $fatal(1);
   end

endmodule
`default_nettype wire
